// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: shared defaults and per-bit action encoding for the switch debouncer
package switch_debouncer_pkg;
  localparam int SW_WIDTH     = 8;
  localparam int SIL_PRESCALE = 1000;
  localparam int SIL_STABLE   = 16;
  localparam int SIM_PRESCALE = 4;
  localparam int SIM_STABLE   = 3;
  typedef enum logic [1:0] {ACT_HOLD, ACT_CLEAR, ACT_COUNT, ACT_FLIP} act_e;
endpackage

// File: rtl/switch_debouncer_bit.sv
// switch_debouncer_bit: one switch - 2-flop synchroniser, integrating debouncer, edge pulses
module switch_debouncer_bit
  import switch_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = SIL_STABLE,
  parameter int   STABLE_W     = 5,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic int_clock,
  input  logic int_reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change_d
);
  logic sync1_q, sync2_q, level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [STABLE_W-1:0] cnt_q, cnt_d;
  act_e act;
  always_comb begin
    act = !tick ? ACT_HOLD :
          sync2_q == level_q ? ACT_CLEAR :
          cnt_q == STABLE_W'(STABLE_TICKS - 1) ? ACT_FLIP : ACT_COUNT;
    cnt_d = act == ACT_COUNT ? cnt_q + STABLE_W'(1) : act == ACT_HOLD ? cnt_q : '0;
    level_d = act == ACT_FLIP ? sync2_q : level_q;
    rise_d = act == ACT_FLIP && sync2_q;
    fall_d = act == ACT_FLIP && !sync2_q;
    change_d = act == ACT_FLIP;
  end
  always_ff @(posedge int_clock or negedge int_reset) begin
    if (!int_reset) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      level_q <= RESET_VALUE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: shared sample-tick prescaler feeding one debouncer per board switch
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int               WIDTH        = SW_WIDTH,
  parameter int               PRESCALE     = SIL_PRESCALE,
  parameter int               PRESCALE_W   = 10,
  parameter int               STABLE_TICKS = SIL_STABLE,
  parameter int               STABLE_W     = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             int_clock,
  input  logic             int_reset,
  input  logic [WIDTH-1:0] switches_in,
  output logic [WIDTH-1:0] switches_out,
  output logic [WIDTH-1:0] switches_rising,
  output logic [WIDTH-1:0] switches_falling,
  output logic             any_change,
  output logic             sample_tick
);
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic tick_q, tick_d, any_q, any_d;
  logic [WIDTH-1:0] change_d;
  // tick_q is registered from the next count so it is high while the count sits at PRESCALE-1
  always_comb begin
    pre_d  = pre_q == PRESCALE_W'(PRESCALE - 1) ? '0 : pre_q + PRESCALE_W'(1);
    tick_d = pre_d == PRESCALE_W'(PRESCALE - 1);
    any_d  = |change_d;
  end
  always_ff @(posedge int_clock or negedge int_reset) begin
    if (!int_reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      any_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      any_q  <= any_d;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debouncer_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .STABLE_W    (STABLE_W),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .int_clock(int_clock),
      .int_reset(int_reset),
      .tick     (tick_q),
      .raw      (switches_in[i]),
      .level    (switches_out[i]),
      .rise     (switches_rising[i]),
      .fall     (switches_falling[i]),
      .change_d (change_d[i])
    );
  end
  assign sample_tick = tick_q;
  assign any_change  = any_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: random and directed stimulus against a tick-window reference model
module tb_switch_debouncer;
  logic clk = 1'b0, rst_n = 1'b0, any_change, sample_tick;
  logic [7:0] sw_in = 8'hFF, sw_out, sw_rise, sw_fall;
  int n_checks = 0, n_fail = 0;

  switch_debouncer #(
    .WIDTH(8), .PRESCALE(4), .PRESCALE_W(2), .STABLE_TICKS(3), .STABLE_W(2), .RESET_VALUE(8'h00)
  ) dut (
    .int_clock(clk), .int_reset(rst_n), .switches_in(sw_in), .switches_out(sw_out),
    .switches_rising(sw_rise), .switches_falling(sw_fall), .any_change(any_change),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {logic [7:0] out, rise, fall; logic any, tick;} exp_t;
  exp_t q[$];
  logic [7:0] s1, s2, m_out, samp[$];
  int edges;

  // A bit flips when its last 3 tick-samples of the synchronised input all disagree with it
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic [7:0] nxt;
    if (!rst_n) begin
      s1 = 8'h00; s2 = 8'h00; m_out = 8'h00; edges = 0;
      samp.delete(); q.delete(); q.push_back(exp_t'(0));
    end else begin
      edges++;
      nxt = m_out;
      if (edges % 4 == 0) begin
        samp.push_back(s2);
        if (samp.size() > 3) void'(samp.pop_front());
        if (samp.size() == 3)
          for (int b = 0; b < 8; b++)
            if (samp[0][b] != m_out[b] && samp[1][b] != m_out[b] && samp[2][b] != m_out[b])
              nxt[b] = ~m_out[b];
      end
      e.out = nxt; e.rise = nxt & ~m_out; e.fall = ~nxt & m_out;
      e.any = |(nxt ^ m_out); e.tick = (edges % 4 == 3);
      m_out = nxt; s2 = s1; s1 = sw_in;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("switches_out", 32'(sw_out), 32'(e.out));
      chk("switches_rising", 32'(sw_rise), 32'(e.rise));
      chk("switches_falling", 32'(sw_fall), 32'(e.fall));
      chk("any_change", 32'(any_change), 32'(e.any));
      chk("sample_tick", 32'(sample_tick), 32'(e.tick));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt;
    bit found;
    cyc(5);
    chk("reset_out", 32'(sw_out), 32'h0);
    chk("reset_pulses", 32'({sw_rise, sw_fall, any_change, sample_tick}), 32'h0);
    rst_n = 1'b1;
    found = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (sw_out == 8'hFF) begin found = 1'b1; cnt = i; end
    end
    chk("release_rise_found", 32'(found), 32'h1);
    chk("release_rise_latency_le15", 32'(cnt <= 15), 32'h1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(sample_tick);
    end
    chk("tick_count_40", 32'(cnt), 32'd10);
    #2;
    sw_in = 8'h00; cyc(20);
    for (int i = 0; i < 5; i++) begin
      sw_in = 8'h01; cyc(4);
      sw_in = 8'h00; cyc(4);
    end
    chk("bounce_held_low", 32'(sw_out), 32'h00);
    sw_in = 8'h01; cyc(20);
    chk("bounce_then_rise", 32'(sw_out), 32'h01);
    sw_in = 8'h0F; cyc(20);
    chk("out_0f", 32'(sw_out), 32'h0F);
    sw_in = 8'hF0; cyc(20);
    chk("out_f0", 32'(sw_out), 32'hF0);
    sw_in = 8'h00; cyc(20);
    sw_in = 8'h08; cyc(10);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_out", 32'(sw_out), 32'h00);
    cyc(20);
    chk("after_reset_rise", 32'(sw_out), 32'h08);
    for (int i = 0; i < 300; i++) begin
      sw_in = sw_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc(int'($urandom_range(1, 16)));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
    end
    cyc(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
